// File: rtl/can_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : can_tx_arbiter
// Purpose  : Lowest-identifier-wins arbiter and retry sequencer that shares a
//            single CAN transmit engine between N_REQ mailbox requesters.
// Revision : 1.0 - initial release
// ============================================================================
module can_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int ID_W        = 11,
  parameter int MAX_RETRY   = 8,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [N_REQ-1:0]         i_req,
  input  logic [N_REQ*ID_W-1:0]    i_req_id,
  output logic [N_REQ-1:0]         o_grant,
  output logic [$clog2(N_REQ)-1:0] o_tx_sel,
  output logic                     o_tx_start,
  input  logic                     i_tx_ack,
  input  logic                     i_tx_done,
  input  logic                     i_tx_lost,
  input  logic                     i_tx_err,
  output logic [N_REQ-1:0]         o_done,
  output logic [N_REQ-1:0]         o_fail,
  output logic                     o_busy
);

  localparam int c_sel_w = $clog2(N_REQ);
  localparam int c_cnt_w = $clog2(MAX_RETRY + 1);
  localparam int c_tmo_w = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [c_cnt_w-1:0] c_cnt_max  = c_cnt_w'(MAX_RETRY);
  localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYC - 1);

  localparam logic [1:0] c_st_idle    = 2'd0;
  localparam logic [1:0] c_st_start   = 2'd1;
  localparam logic [1:0] c_st_wait    = 2'd2;
  localparam logic [1:0] c_st_release = 2'd3;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [c_sel_w-1:0] r_sel;
  logic [c_sel_w-1:0] w_sel_nxt;
  logic [N_REQ-1:0]   r_mask;
  logic [c_tmo_w-1:0] r_tmo_cnt;

  logic [N_REQ-1:0][c_cnt_w-1:0] w_err_cnt;

  logic [N_REQ-1:0]   w_elig;
  logic               w_any;
  logic [c_sel_w-1:0] w_win;
  logic [ID_W-1:0]    w_win_id;

  logic               w_tmo;
  logic               w_req_sel;
  logic [c_cnt_w-1:0] w_cnt_inc;
  logic               w_exhaust;
  logic               w_start_err;
  logic               w_wait_err;
  logic               w_wait_done;
  logic               w_err_evt;

  logic [N_REQ-1:0]   w_grant_nxt;
  logic [c_sel_w-1:0] w_tx_sel_nxt;
  logic               w_start_nxt;
  logic               w_busy_nxt;
  logic [N_REQ-1:0]   w_done_nxt;
  logic [N_REQ-1:0]   w_fail_nxt;
  logic [N_REQ-1:0]   w_mask_nxt;

  // Strict less-than keeps the earlier (lower) index on an identifier tie.
  always_comb begin
    w_elig   = i_req & ~r_mask;
    w_any    = 1'b0;
    w_win    = '0;
    w_win_id = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_elig[k] && (!w_any || (i_req_id[k*ID_W +: ID_W] < w_win_id))) begin
        w_any    = 1'b1;
        w_win    = c_sel_w'(k);
        w_win_id = i_req_id[k*ID_W +: ID_W];
      end
    end
  end

  // Engine events qualified by state; done outranks err/timeout, which outrank lost.
  always_comb begin
    w_tmo       = (r_tmo_cnt == c_tmo_last);
    w_req_sel   = i_req[r_sel];
    w_cnt_inc   = w_err_cnt[r_sel] + c_cnt_w'(1);
    w_exhaust   = (w_cnt_inc == c_cnt_max);
    w_start_err = (r_state == c_st_start) && !i_tx_ack && w_req_sel && w_tmo;
    w_wait_done = (r_state == c_st_wait) && i_tx_done;
    w_wait_err  = (r_state == c_st_wait) && !i_tx_done && (i_tx_err || w_tmo);
    w_err_evt   = w_start_err || w_wait_err;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    case (r_state)
      c_st_idle: begin
        if (w_any) begin
          w_state_nxt = c_st_start;
          w_sel_nxt   = w_win;
        end
      end
      c_st_start: begin
        if (i_tx_ack) begin
          w_state_nxt = c_st_wait;
        end else if (!w_req_sel) begin
          w_state_nxt = c_st_idle;
        end else if (w_err_evt) begin
          w_state_nxt = w_exhaust ? c_st_release : c_st_idle;
        end
      end
      c_st_wait: begin
        if (w_wait_done) begin
          w_state_nxt = c_st_release;
        end else if (w_err_evt) begin
          w_state_nxt = w_exhaust ? c_st_release : c_st_idle;
        end else if (i_tx_lost) begin
          w_state_nxt = c_st_idle;
        end
      end
      c_st_release: w_state_nxt = c_st_idle;
      default:      w_state_nxt = c_st_idle;
    endcase
  end

  // Next values for the registered outputs, decoded from the next state.
  always_comb begin
    w_grant_nxt  = '0;
    w_tx_sel_nxt = '0;
    w_done_nxt   = '0;
    w_fail_nxt   = '0;
    w_mask_nxt   = '0;
    w_start_nxt  = (w_state_nxt == c_st_start);
    w_busy_nxt   = (w_state_nxt != c_st_idle);
    if ((w_state_nxt == c_st_start) || (w_state_nxt == c_st_wait)) begin
      w_grant_nxt[w_sel_nxt] = 1'b1;
      w_tx_sel_nxt           = w_sel_nxt;
    end
    if (w_wait_done) begin
      w_done_nxt[r_sel] = 1'b1;
    end
    if (w_err_evt && w_exhaust) begin
      w_fail_nxt[r_sel] = 1'b1;
    end
    if (w_state_nxt == c_st_release) begin
      w_mask_nxt[r_sel] = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= c_st_idle;
      r_sel      <= '0;
      r_mask     <= '0;
      o_grant    <= '0;
      o_tx_sel   <= '0;
      o_tx_start <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= '0;
      o_fail     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_sel      <= w_sel_nxt;
      r_mask     <= w_mask_nxt;
      o_grant    <= w_grant_nxt;
      o_tx_sel   <= w_tx_sel_nxt;
      o_tx_start <= w_start_nxt;
      o_busy     <= w_busy_nxt;
      o_done     <= w_done_nxt;
      o_fail     <= w_fail_nxt;
    end
  end

  // Holds at the last value so an ack landing on the expiry cycle still times out in WAIT.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tmo_cnt <= '0;
    end else if ((r_state != c_st_start) && (w_state_nxt == c_st_start)) begin
      r_tmo_cnt <= '0;
    end else if (((r_state == c_st_start) || (r_state == c_st_wait)) && !w_tmo) begin
      r_tmo_cnt <= r_tmo_cnt + c_tmo_w'(1);
    end
  end

  generate
    for (genvar g = 0; g < N_REQ; g++) begin : g_err_cnt
      logic [c_cnt_w-1:0] r_cnt;

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_cnt <= '0;
        end else if (r_sel == c_sel_w'(g)) begin
          if (w_wait_done || (w_err_evt && w_exhaust)) begin
            r_cnt <= '0;
          end else if (w_err_evt) begin
            r_cnt <= w_cnt_inc;
          end
        end
      end

      assign w_err_cnt[g] = r_cnt;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_can_tx_arbiter.sv
`default_nettype none
// Bench for can_tx_arbiter: directed scenarios with literal expectations, plus a
// transaction-rule reference model compared against every output on every cycle.
module tb_can_tx_arbiter;

  localparam int N    = 4;
  localparam int IDW  = 11;
  localparam int MAXR = 3;
  localparam int TMO  = 16;

  typedef enum logic [1:0] {PH_IDLE, PH_START, PH_WAIT, PH_REL} ph_t;

  typedef struct packed {
    ph_t             ph;
    logic [1:0]      sel;
    logic [3:0][3:0] cnt;
    logic [7:0]      age;
    logic [3:0]      grant;
    logic [1:0]      txsel;
    logic            start;
    logic            busy;
    logic [3:0]      done;
    logic [3:0]      fail;
  } model_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*IDW-1:0] req_id = '0;
  logic           tx_ack = 1'b0;
  logic           tx_done = 1'b0;
  logic           tx_lost = 1'b0;
  logic           tx_err = 1'b0;

  logic [N-1:0]   o_grant;
  logic [1:0]     o_tx_sel;
  logic           o_tx_start;
  logic [N-1:0]   o_done;
  logic [N-1:0]   o_fail;
  logic           o_busy;

  int n_checks = 0;
  int n_err    = 0;

  model_t m;

  can_tx_arbiter #(
    .N_REQ(N), .ID_W(IDW), .MAX_RETRY(MAXR), .TIMEOUT_CYC(TMO)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_req_id(req_id),
    .o_grant(o_grant), .o_tx_sel(o_tx_sel), .o_tx_start(o_tx_start),
    .i_tx_ack(tx_ack), .i_tx_done(tx_done), .i_tx_lost(tx_lost), .i_tx_err(tx_err),
    .o_done(o_done), .o_fail(o_fail), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  // Winner = smallest (identifier, index) key among eligible requesters.
  function automatic int winner(logic [3:0] elig, logic [N*IDW-1:0] ids);
    int best = -1;
    longint bestkey = 0;
    for (int k = 0; k < N; k++) begin
      if (elig[k]) begin
        longint key = longint'(ids[k*IDW +: IDW]) * 16 + k;
        if (best < 0 || key < bestkey) begin
          best = k;
          bestkey = key;
        end
      end
    end
    return best;
  endfunction

  function automatic model_t bump(model_t r);
    model_t o = r;
    if (int'(r.cnt[r.sel]) + 1 == MAXR) begin
      o.fail[r.sel] = 1'b1;
      o.cnt[r.sel]  = '0;
      o.ph          = PH_REL;
    end else begin
      o.cnt[r.sel] = r.cnt[r.sel] + 4'd1;
      o.ph         = PH_IDLE;
    end
    return o;
  endfunction

  function automatic model_t step(model_t mi, logic [3:0] rq, logic [N*IDW-1:0] ids,
                                  logic ack, logic dn, logic lost, logic err);
    model_t r = mi;
    int w;
    r.done = '0;
    r.fail = '0;
    case (mi.ph)
      PH_IDLE: begin
        w = winner(rq, ids);
        if (w >= 0) begin
          r.ph  = PH_START;
          r.sel = 2'(w);
          r.age = '0;
        end
      end
      PH_START: begin
        r.age = mi.age + 8'd1;
        if (ack) r.ph = PH_WAIT;
        else if (!rq[mi.sel]) r.ph = PH_IDLE;
        else if (mi.age >= 8'(TMO - 1)) r = bump(r);
      end
      PH_WAIT: begin
        r.age = mi.age + 8'd1;
        if (dn) begin
          r.done[mi.sel] = 1'b1;
          r.cnt[mi.sel]  = '0;
          r.ph           = PH_REL;
        end else if (err || mi.age >= 8'(TMO - 1)) begin
          r = bump(r);
        end else if (lost) begin
          r.ph = PH_IDLE;
        end
      end
      default: r.ph = PH_IDLE;
    endcase
    r.start = (r.ph == PH_START);
    r.busy  = (r.ph != PH_IDLE);
    r.grant = (r.ph == PH_START || r.ph == PH_WAIT) ? 4'(1 << r.sel) : 4'd0;
    r.txsel = (r.ph == PH_START || r.ph == PH_WAIT) ? r.sel : 2'd0;
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= '0;
    else     m <= step(m, req, req_id, tx_ack, tx_done, tx_lost, tx_err);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("cycle_model",
          32'({o_grant, o_tx_sel, o_tx_start, o_busy, o_done, o_fail}),
          32'({m.grant, m.txsel, m.start, m.busy, m.done, m.fail}));
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic set_id(input int k, input logic [IDW-1:0] id);
    req_id[k*IDW +: IDW] = id;
  endtask

  // Called in the first START cycle of requester k: ack, complete, release.
  task automatic serve(input int k);
    check("serve_start", 32'(o_tx_start), 32'd1);
    tx_ack = 1'b1;
    cyc(1);
    tx_ack = 1'b0;
    check("serve_ack_drop", 32'(o_tx_start), 32'd0);
    cyc(2);
    tx_done = 1'b1;
    cyc(1);
    tx_done = 1'b0;
    check("serve_done", 32'(o_done), 32'(1 << k));
    req[k] = 1'b0;
    cyc(1);
    check("serve_done_clr", 32'(o_done), 32'd0);
    check("serve_idle", 32'(o_busy), 32'd0);
  endtask

  initial begin
    cyc(2);
    check("rst_grant", 32'(o_grant), 32'd0);
    check("rst_start", 32'(o_tx_start), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_sel", 32'(o_tx_sel), 32'd0);
    check("rst_done_fail", 32'({o_done, o_fail}), 32'd0);
    rst = 1'b0;
    cyc(1);

    // Single request with ack after 3 cycles
    set_id(2, 11'h123);
    req[2] = 1'b1;
    cyc(1);
    check("t1_grant", 32'(o_grant), 32'b0100);
    check("t1_sel", 32'(o_tx_sel), 32'd2);
    check("t1_start", 32'(o_tx_start), 32'd1);
    check("t1_busy", 32'(o_busy), 32'd1);
    cyc(2);
    tx_ack = 1'b1;
    cyc(1);
    tx_ack = 1'b0;
    check("t1_ack_start", 32'(o_tx_start), 32'd0);
    check("t1_wait_grant", 32'(o_grant), 32'b0100);
    cyc(9);
    tx_done = 1'b1;
    cyc(1);
    tx_done = 1'b0;
    check("t1_done", 32'(o_done), 32'b0100);
    check("t1_rel_grant", 32'(o_grant), 32'd0);
    check("t1_rel_busy", 32'(o_busy), 32'd1);
    req[2] = 1'b0;
    cyc(1);
    check("t1_done_once", 32'(o_done), 32'd0);
    check("t1_busy_low", 32'(o_busy), 32'd0);

    // Priority: lower identifier first, then tie goes to lower index
    set_id(0, 11'h300);
    set_id(3, 11'h050);
    req[0] = 1'b1;
    req[3] = 1'b1;
    cyc(1);
    check("t2_first", 32'(o_grant), 32'b1000);
    serve(3);
    cyc(1);
    check("t2_second", 32'(o_grant), 32'b0001);
    serve(0);
    set_id(0, 11'h100);
    set_id(3, 11'h100);
    req[0] = 1'b1;
    req[3] = 1'b1;
    cyc(1);
    check("t2_tie", 32'(o_grant), 32'b0001);
    serve(0);
    cyc(1);
    check("t2_tie_next", 32'(o_grant), 32'b1000);
    serve(3);

    // Arbitration loss lets a higher-priority request in
    set_id(1, 11'h200);
    req[1] = 1'b1;
    cyc(1);
    check("t3_grant", 32'(o_grant), 32'b0010);
    tx_ack = 1'b1;
    cyc(1);
    tx_ack = 1'b0;
    set_id(2, 11'h010);
    req[2] = 1'b1;
    cyc(1);
    check("t3_wait_hold", 32'(o_grant), 32'b0010);
    tx_lost = 1'b1;
    cyc(1);
    tx_lost = 1'b0;
    check("t3_lost_idle", 32'(o_busy), 32'd0);
    cyc(1);
    check("t3_regrant", 32'(o_grant), 32'b0100);
    serve(2);
    cyc(1);
    check("t3_back", 32'(o_grant), 32'b0010);
    check("t3_model_cnt1", 32'(m.cnt[1]), 32'd0);
    serve(1);

    // Retry exhaustion after MAX_RETRY errors
    set_id(0, 11'h0AA);
    req[0] = 1'b1;
    for (int a = 1; a <= MAXR; a++) begin
      cyc(1);
      check("t4_attempt_start", 32'(o_tx_start), 32'd1);
      check("t4_attempt_grant", 32'(o_grant), 32'b0001);
      tx_ack = 1'b1;
      cyc(1);
      tx_ack = 1'b0;
      tx_err = 1'b1;
      cyc(1);
      tx_err = 1'b0;
      if (a < MAXR) begin
        check("t4_retry_idle", 32'(o_busy), 32'd0);
        check("t4_no_fail_yet", 32'(o_fail), 32'd0);
      end else begin
        check("t4_fail", 32'(o_fail), 32'b0001);
        check("t4_no_done", 32'(o_done), 32'd0);
        req[0] = 1'b0;
      end
    end
    cyc(1);
    check("t4_model_cnt0", 32'(m.cnt[0]), 32'd0);
    cyc(2);
    check("t4_quiet", 32'(o_busy), 32'd0);

    // Timeout without ack counts as an error and retries
    set_id(3, 11'h7FF);
    req[3] = 1'b1;
    cyc(1);
    for (int i = 0; i < TMO; i++) begin
      check("t5_start_held", 32'(o_tx_start), 32'd1);
      cyc(1);
    end
    check("t5_tmo_drop", 32'(o_tx_start), 32'd0);
    check("t5_tmo_idle", 32'(o_busy), 32'd0);
    check("t5_no_fail", 32'(o_fail), 32'd0);
    check("t5_model_cnt3", 32'(m.cnt[3]), 32'd1);
    cyc(1);
    check("t5_retry", 32'(o_grant), 32'b1000);
    serve(3);

    // Request withdrawn in START aborts silently
    set_id(2, 11'h0F0);
    req[2] = 1'b1;
    cyc(1);
    check("t8_start", 32'(o_tx_start), 32'd1);
    req[2] = 1'b0;
    cyc(1);
    check("t8_abort_idle", 32'(o_busy), 32'd0);
    check("t8_no_pulse", 32'({o_done, o_fail}), 32'd0);

    // Engine events while idle are ignored
    tx_ack = 1'b1; tx_done = 1'b1; tx_err = 1'b1; tx_lost = 1'b1;
    cyc(1);
    tx_ack = 1'b0; tx_done = 1'b0; tx_err = 1'b0; tx_lost = 1'b0;
    check("t9_spur_busy", 32'(o_busy), 32'd0);
    check("t9_spur_done", 32'(o_done), 32'd0);

    // done and err in the same cycle: done wins
    set_id(1, 11'h111);
    req[1] = 1'b1;
    cyc(1);
    tx_ack = 1'b1;
    cyc(1);
    tx_ack = 1'b0;
    tx_done = 1'b1;
    tx_err = 1'b1;
    cyc(1);
    tx_done = 1'b0;
    tx_err = 1'b0;
    check("t6_done", 32'(o_done), 32'b0010);
    check("t6_no_fail", 32'(o_fail), 32'd0);
    check("t6_model_cnt1", 32'(m.cnt[1]), 32'd0);
    req[1] = 1'b0;
    cyc(1);

    // Reset in WAIT clears outputs immediately and restarts cleanly
    set_id(0, 11'h055);
    req[0] = 1'b1;
    cyc(1);
    tx_ack = 1'b1;
    cyc(1);
    tx_ack = 1'b0;
    cyc(2);
    check("t7_wait", 32'(o_grant), 32'b0001);
    rst = 1'b1;
    #1;
    check("t7_rst_grant", 32'(o_grant), 32'd0);
    check("t7_rst_busy", 32'(o_busy), 32'd0);
    check("t7_rst_sel", 32'(o_tx_sel), 32'd0);
    cyc(1);
    rst = 1'b0;
    cyc(1);
    check("t7_restart", 32'(o_grant), 32'b0001);
    serve(0);
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
